// File: rtl/hsiao_pkg.sv
// Hsiao SEC-DED helpers shared by the codec and its parity tree.
//   hsiao_check_bits(data_w) : number of check bits P for a data width
//   hsiao_column(data_w, i)  : H-matrix column (P bits, LSB-aligned) of data bit i
//   OP_ENC / OP_DEC          : operation encoding on in_op
package hsiao_pkg;

  localparam logic OP_ENC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  // 64 data bits need 8 check bits; nothing wider is supported.
  localparam int MAX_P = 8;

  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int t = 1; t <= MAX_P; t++) begin
      if (t <= k) r = r * (n - k + t) / t;
    end
    return r;
  endfunction

  function automatic int popcount(input logic [MAX_P-1:0] x);
    int c;
    c = 0;
    for (int b = 0; b < MAX_P; b++) begin
      if (x[b]) c++;
    end
    return c;
  endfunction

  // Smallest r whose odd-weight (>=3) column pool covers data_w.
  // Scanning downward leaves the smallest qualifying r in result.
  function automatic int hsiao_check_bits(input int data_w);
    int result;
    int total;
    result = MAX_P;
    for (int r = MAX_P; r >= 2; r--) begin
      total = 0;
      for (int w = 3; w <= MAX_P; w += 2) begin
        if (w <= r) total += binom(r, w);
      end
      if (total >= data_w) result = r;
    end
    return result;
  endfunction

  // Columns are handed out by weight (3, 5, 7), ascending value within a weight.
  function automatic logic [MAX_P-1:0] hsiao_column(input int data_w, input int i);
    int p;
    int seen;
    logic [MAX_P-1:0] col;
    p    = hsiao_check_bits(data_w);
    seen = 0;
    col  = '0;
    for (int w = 3; w <= MAX_P; w += 2) begin
      for (int v = 0; v < (1 << MAX_P); v++) begin
        if (w <= p && v < (1 << p) && popcount(MAX_P'(v)) == w) begin
          if (seen == i) col = MAX_P'(v);
          seen++;
        end
      end
    end
    return col;
  endfunction

endpackage

// File: rtl/hsiao_check_gen.sv
// Combinational Hsiao parity tree.
//   data  [DATA_W-1:0] : data field
//   check [P-1:0]      : check bits, bit j = XOR of data bits whose column has bit j set
module hsiao_check_gen
  import hsiao_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int P      = hsiao_check_bits(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [P-1:0]      check
);

  logic [P-1:0] col [DATA_W];

  for (genvar i = 0; i < DATA_W; i++) begin : g_col
    localparam logic [MAX_P-1:0] COL = hsiao_column(DATA_W, i);
    assign col[i] = COL[P-1:0];
  end

  always_comb begin
    check = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) check = check ^ col[i];
    end
  end

endmodule

// File: rtl/hsiao_secded_codec.sv
// Two-stage pipelined Hsiao SEC-DED encoder/decoder on a valid/ready stream,
// with saturating single/double error counters.
//   clk, rst_n                      : clock, async active-low reset
//   in_valid/in_ready/in_op/in_word : input stream (in_op 0 = encode, 1 = decode)
//   out_valid/out_ready             : output stream handshake
//   out_code/out_data               : (corrected) codeword and data field
//   out_sbe/out_dbe/out_syndrome    : error flags and raw syndrome
//   cnt_clr, sbe_count, dbe_count   : counter clear and saturating counts
module hsiao_secded_codec
  import hsiao_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 16,
  localparam int P      = hsiao_check_bits(DATA_W),
  localparam int CODE_W = DATA_W + P
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_op,
  input  logic [CODE_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sbe,
  output logic              out_dbe,
  output logic [P-1:0]      out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sbe_count,
  output logic [CNT_W-1:0]  dbe_count
);

  logic              s1_valid_q, s1_valid_d;
  logic              s1_op_q, s1_op_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [P-1:0]      s1_chk_q, s1_chk_d;

  logic              out_valid_q, out_valid_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sbe_q, out_sbe_d;
  logic              out_dbe_q, out_dbe_d;
  logic [P-1:0]      out_syn_q, out_syn_d;

  logic [CNT_W-1:0]  sbe_cnt_q, sbe_cnt_d;
  logic [CNT_W-1:0]  dbe_cnt_q, dbe_cnt_d;

  logic              s2_load;
  logic [P-1:0]      calc_chk;
  logic [P-1:0]      syn;
  logic [CODE_W-1:0] flip;
  logic              sbe;
  logic              dbe;
  logic [CODE_W-1:0] code;
  logic              out_hs;

  logic [P-1:0]      col [DATA_W];

  for (genvar i = 0; i < DATA_W; i++) begin : g_col
    localparam logic [MAX_P-1:0] COL = hsiao_column(DATA_W, i);
    assign col[i] = COL[P-1:0];
  end

  assign s2_load  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign out_hs   = out_valid_q && out_ready;

  // S1 keeps the data and received check bits split, so the single parity
  // tree serves both encode (check generation) and decode (recomputation).
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_data_d  = s1_data_q;
    s1_chk_d   = s1_chk_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = in_op;
        if (in_op == OP_DEC) begin
          s1_data_d = in_word[CODE_W-1:P];
          s1_chk_d  = in_word[P-1:0];
        end else begin
          s1_data_d = in_word[DATA_W-1:0];
          s1_chk_d  = '0;
        end
      end
    end
  end

  hsiao_check_gen #(
    .DATA_W (DATA_W),
    .P      (P)
  ) u_check_gen (
    .data  (s1_data_q),
    .check (calc_chk)
  );

  // Every column has odd weight and is unique, so at most one flip bit is set
  // and an even-weight syndrome never matches.
  always_comb begin
    syn  = '0;
    flip = '0;
    if (s1_op_q == OP_DEC) syn = s1_chk_q ^ calc_chk;
    for (int i = 0; i < DATA_W; i++) begin
      if (syn == col[i]) flip[P+i] = 1'b1;
    end
    for (int j = 0; j < P; j++) begin
      if (syn == P'(1 << j)) flip[j] = 1'b1;
    end
    sbe = |flip;
    dbe = (syn != '0) && !sbe;
    if (s1_op_q == OP_DEC) code = {s1_data_q, s1_chk_q} ^ flip;
    else                   code = {s1_data_q, calc_chk};
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_data_d  = out_data_q;
    out_sbe_d   = out_sbe_q;
    out_dbe_d   = out_dbe_q;
    out_syn_d   = out_syn_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_code_d = code;
        out_data_d = code[CODE_W-1:P];
        out_sbe_d  = sbe;
        out_dbe_d  = dbe;
        out_syn_d  = syn;
      end
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_comb begin
    sbe_cnt_d = sbe_cnt_q;
    dbe_cnt_d = dbe_cnt_q;
    if (cnt_clr) begin
      sbe_cnt_d = '0;
      dbe_cnt_d = '0;
    end else begin
      if (out_hs && out_sbe_q && sbe_cnt_q != '1) sbe_cnt_d = sbe_cnt_q + CNT_W'(1);
      if (out_hs && out_dbe_q && dbe_cnt_q != '1) dbe_cnt_d = dbe_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ENC;
      s1_data_q   <= '0;
      s1_chk_q    <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_data_q  <= '0;
      out_sbe_q   <= 1'b0;
      out_dbe_q   <= 1'b0;
      out_syn_q   <= '0;
      sbe_cnt_q   <= '0;
      dbe_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_data_q   <= s1_data_d;
      s1_chk_q    <= s1_chk_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_data_q  <= out_data_d;
      out_sbe_q   <= out_sbe_d;
      out_dbe_q   <= out_dbe_d;
      out_syn_q   <= out_syn_d;
      sbe_cnt_q   <= sbe_cnt_d;
      dbe_cnt_q   <= dbe_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_code     = out_code_q;
  assign out_data     = out_data_q;
  assign out_sbe      = out_sbe_q;
  assign out_dbe      = out_dbe_q;
  assign out_syndrome = out_syn_q;
  assign sbe_count    = sbe_cnt_q;
  assign dbe_count    = dbe_cnt_q;

endmodule

// File: tb/tb_hsiao_secded_codec.sv
// Self-checking bench: DATA_W=8/CNT_W=2 main instance driven from a vector
// table plus stall, counter and reset sequences; DATA_W=16/32/64 instances
// checked against a column-rule reference model.
module tb_hsiao_secded_codec;

  int checks = 0;
  int errors = 0;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [12:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_code;
  logic [7:0]  out_data;
  logic        out_sbe;
  logic        out_dbe;
  logic [4:0]  out_syndrome;
  logic        cnt_clr;
  logic [1:0]  sbe_count;
  logic [1:0]  dbe_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hsiao_secded_codec #(.DATA_W(8), .CNT_W(2)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_word      (in_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_code     (out_code),
    .out_data     (out_data),
    .out_sbe      (out_sbe),
    .out_dbe      (out_dbe),
    .out_syndrome (out_syndrome),
    .cnt_clr      (cnt_clr),
    .sbe_count    (sbe_count),
    .dbe_count    (dbe_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference H-matrix column: weight 3 ascending, then weight 5, then 7.
  function automatic logic [7:0] ref_col(input int p, input int i);
    int n;
    n = 0;
    for (int w = 3; w <= p; w += 2) begin
      for (int v = 1; v < (1 << p); v++) begin
        if ($countones(v) == w) begin
          if (n == i) return 8'(v);
          n++;
        end
      end
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_chk(input int p, input int dw, input logic [63:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < dw; i++) begin
      if (d[i]) c = c ^ ref_col(p, i);
    end
    return c;
  endfunction

  // Wide instances run their own directed checks against the reference model.
  for (genvar g = 0; g < 3; g++) begin : g_w
    localparam int DW = 16 << g;
    localparam int PW = (g == 0) ? 6 : (g == 1) ? 7 : 8;
    localparam int CW = DW + PW;

    logic          w_in_valid, w_in_op, w_in_ready;
    logic          w_out_valid, w_out_sbe, w_out_dbe;
    logic [CW-1:0] w_in_word, w_out_code;
    logic [DW-1:0] w_out_data;
    logic [PW-1:0] w_out_syn;
    logic [7:0]    w_sbe_cnt, w_dbe_cnt;
    logic          done_w = 1'b0;

    logic [63:0]   pats [4];
    logic          t_op   [4];
    logic [CW-1:0] t_word [4];
    logic [CW-1:0] t_code [4];
    logic          t_sbe  [4];
    logic          t_dbe  [4];
    logic [PW-1:0] t_syn  [4];

    hsiao_secded_codec #(.DATA_W(DW), .CNT_W(8)) u_w (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (w_in_valid),
      .in_ready     (w_in_ready),
      .in_op        (w_in_op),
      .in_word      (w_in_word),
      .out_valid    (w_out_valid),
      .out_ready    (1'b1),
      .out_code     (w_out_code),
      .out_data     (w_out_data),
      .out_sbe      (w_out_sbe),
      .out_dbe      (w_out_dbe),
      .out_syndrome (w_out_syn),
      .cnt_clr      (1'b0),
      .sbe_count    (w_sbe_cnt),
      .dbe_count    (w_dbe_cnt)
    );

    initial begin
      int n, k, k2, j, es, ed;
      logic [DW-1:0] d;
      logic [7:0]    c8, ca, cb;
      logic [CW-1:0] code;
      pats[0] = 64'h0123456789ABCDEF;
      pats[1] = 64'hFFFFFFFFFFFFFFFF;
      pats[2] = 64'h0000000000000001;
      pats[3] = 64'hDEADBEEFCAFEF00D;
      w_in_valid = 1'b0;
      w_in_op    = 1'b0;
      w_in_word  = '0;
      es = 0;
      ed = 0;
      wait (rst_n === 1'b1);
      @(posedge clk); #1;
      for (int pi = 0; pi < 4; pi++) begin
        d    = pats[pi][DW-1:0];
        c8   = ref_chk(PW, DW, 64'(d));
        code = {d, c8[PW-1:0]};
        k    = (pi * 7 + 3) % DW;
        k2   = (k + 1) % DW;
        j    = pi % PW;
        ca   = ref_col(PW, k);
        cb   = ref_col(PW, k2);
        t_op[0] = 1'b0; t_word[0] = {{PW{1'b1}}, d}; t_code[0] = code;
        t_sbe[0] = 1'b0; t_dbe[0] = 1'b0; t_syn[0] = '0;
        t_op[1] = 1'b1; t_word[1] = code ^ (CW'(1) << (PW + k)); t_code[1] = code;
        t_sbe[1] = 1'b1; t_dbe[1] = 1'b0; t_syn[1] = ca[PW-1:0];
        t_op[2] = 1'b1; t_word[2] = code ^ (CW'(1) << j); t_code[2] = code;
        t_sbe[2] = 1'b1; t_dbe[2] = 1'b0; t_syn[2] = PW'(1 << j);
        t_op[3] = 1'b1; t_word[3] = code ^ (CW'(1) << (PW + k)) ^ (CW'(1) << (PW + k2));
        t_code[3] = t_word[3]; t_sbe[3] = 1'b0; t_dbe[3] = 1'b1;
        t_syn[3] = ca[PW-1:0] ^ cb[PW-1:0];
        for (int x = 0; x < 4; x++) begin
          w_in_valid = 1'b1;
          w_in_op    = t_op[x];
          w_in_word  = t_word[x];
          n = 0;
          do begin
            @(posedge clk); #1;
            w_in_valid = 1'b0;
            n++;
          end while (!w_out_valid && n < 8);
          chk($sformatf("w%0d_p%0d_t%0d_lat", DW, pi, x), n, 2);
          chk($sformatf("w%0d_p%0d_t%0d_code", DW, pi, x), w_out_code, t_code[x]);
          chk($sformatf("w%0d_p%0d_t%0d_data", DW, pi, x), w_out_data, t_code[x][CW-1:PW]);
          chk($sformatf("w%0d_p%0d_t%0d_sbe", DW, pi, x), w_out_sbe, t_sbe[x]);
          chk($sformatf("w%0d_p%0d_t%0d_dbe", DW, pi, x), w_out_dbe, t_dbe[x]);
          chk($sformatf("w%0d_p%0d_t%0d_syn", DW, pi, x), w_out_syn, t_syn[x]);
          if (t_sbe[x]) es++;
          if (t_dbe[x]) ed++;
        end
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk($sformatf("w%0d_sbe_count", DW), w_sbe_cnt, es);
      chk($sformatf("w%0d_dbe_count", DW), w_dbe_cnt, ed);
      done_w = 1'b1;
    end
  end

  typedef struct {
    logic        op;
    logic [12:0] word;
    logic [12:0] code;
    logic [7:0]  data;
    logic        sbe;
    logic        dbe;
    logic [4:0]  syn;
  } vec_t;

  vec_t vecs [16];

  // Drive one word with the pipeline empty and wait (bounded) for its result.
  task automatic send_one(input logic op, input logic [12:0] w, output int lat);
    in_valid = 1'b1;
    in_op    = op;
    in_word  = w;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 8);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, es, ed, sent, got, m, nv;
    int idx [10];
    logic stall;
    logic [12:0] h_code;
    logic [7:0]  h_data;
    logic        h_sbe, h_dbe;
    logic [4:0]  h_syn;
    logic        hs_in, hs_out;

    //          op    word      code      data   sbe   dbe   syn
    vecs[0]  = '{1'b0, 13'h0001, 13'h0027, 8'h01, 1'b0, 1'b0, 5'h00};
    vecs[1]  = '{1'b0, 13'h00FF, 13'h1FE6, 8'hFF, 1'b0, 1'b0, 5'h00};
    vecs[2]  = '{1'b0, 13'h0000, 13'h0000, 8'h00, 1'b0, 1'b0, 5'h00};
    vecs[3]  = '{1'b0, 13'h1F01, 13'h0027, 8'h01, 1'b0, 1'b0, 5'h00};
    vecs[4]  = '{1'b0, 13'h00A5, 13'h14A6, 8'hA5, 1'b0, 1'b0, 5'h00};
    vecs[5]  = '{1'b1, 13'h0027, 13'h0027, 8'h01, 1'b0, 1'b0, 5'h00};
    vecs[6]  = '{1'b1, 13'h0007, 13'h0027, 8'h01, 1'b1, 1'b0, 5'h07};
    vecs[7]  = '{1'b1, 13'h0023, 13'h0027, 8'h01, 1'b1, 1'b0, 5'h04};
    vecs[8]  = '{1'b1, 13'h0024, 13'h0024, 8'h01, 1'b0, 1'b1, 5'h03};
    vecs[9]  = '{1'b1, 13'h0FE6, 13'h1FE6, 8'hFF, 1'b1, 1'b0, 5'h19};
    vecs[10] = '{1'b1, 13'h001C, 13'h001C, 8'h00, 1'b0, 1'b1, 5'h1C};
    vecs[11] = '{1'b1, 13'h001F, 13'h001F, 8'h00, 1'b0, 1'b1, 5'h1F};
    vecs[12] = '{1'b1, 13'h0001, 13'h0000, 8'h00, 1'b1, 1'b0, 5'h01};
    vecs[13] = '{1'b1, 13'h14A6, 13'h14A6, 8'hA5, 1'b0, 1'b0, 5'h00};
    vecs[14] = '{1'b1, 13'h14B6, 13'h14A6, 8'hA5, 1'b1, 1'b0, 5'h10};
    vecs[15] = '{1'b1, 13'h15A6, 13'h14A6, 8'hA5, 1'b1, 1'b0, 5'h0E};
    idx = '{0, 6, 8, 1, 9, 5, 10, 4, 7, 15};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_word   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid_after", out_valid, 1'b0);
    chk("rst_out_code", out_code, 13'h0);
    chk("rst_out_data", out_data, 8'h0);
    chk("rst_out_flags", {out_sbe, out_dbe}, 2'b00);
    chk("rst_out_syndrome", out_syndrome, 5'h0);
    chk("rst_sbe_count", sbe_count, 2'd0);
    chk("rst_dbe_count", dbe_count, 2'd0);

    // Table-driven single transactions, counters tracked with saturation at 3.
    es = 0;
    ed = 0;
    for (int v = 0; v < 16; v++) begin
      chk($sformatf("v%0d_in_ready", v), in_ready, 1'b1);
      send_one(vecs[v].op, vecs[v].word, lat);
      chk($sformatf("v%0d_latency", v), lat, 2);
      chk($sformatf("v%0d_code", v), out_code, vecs[v].code);
      chk($sformatf("v%0d_data", v), out_data, vecs[v].data);
      chk($sformatf("v%0d_sbe", v), out_sbe, vecs[v].sbe);
      chk($sformatf("v%0d_dbe", v), out_dbe, vecs[v].dbe);
      chk($sformatf("v%0d_syndrome", v), out_syndrome, vecs[v].syn);
      if (vecs[v].sbe && es < 3) es++;
      if (vecs[v].dbe && ed < 3) ed++;
      @(posedge clk); #1;
      chk($sformatf("v%0d_sbe_count", v), sbe_count, es);
      chk($sformatf("v%0d_dbe_count", v), dbe_count, ed);
      chk($sformatf("v%0d_drained", v), out_valid, 1'b0);
    end

    // Back-pressure: 10 mixed words with random out_ready.
    sent  = 0;
    got   = 0;
    stall = 1'b0;
    h_code = '0; h_data = '0; h_sbe = 1'b0; h_dbe = 1'b0; h_syn = '0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      if (stall) begin
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_code", out_code, h_code);
        chk("bp_hold_data", out_data, h_data);
        chk("bp_hold_flags", {out_sbe, out_dbe, out_syndrome}, {h_sbe, h_dbe, h_syn});
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 10) begin
        in_valid = 1'b1;
        in_op    = vecs[idx[sent]].op;
        in_word  = vecs[idx[sent]].word;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        chk($sformatf("bp%0d_code", got), out_code, vecs[idx[got]].code);
        chk($sformatf("bp%0d_data", got), out_data, vecs[idx[got]].data);
        chk($sformatf("bp%0d_flags", got), {out_sbe, out_dbe, out_syndrome},
            {vecs[idx[got]].sbe, vecs[idx[got]].dbe, vecs[idx[got]].syn});
        got++;
      end
      stall  = out_valid && !out_ready;
      h_code = out_code; h_data = out_data;
      h_sbe  = out_sbe;  h_dbe  = out_dbe; h_syn = out_syndrome;
      if (hs_in) sent++;
      @(posedge clk); #1;
    end
    chk("bp_delivered", got, 10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nv = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) nv++;
    end
    chk("bp_no_extra_output", nv, 0);

    // Clear, then 5 back-to-back SBE words: count must saturate at 3.
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_sbe_count", sbe_count, 2'd0);
    chk("clr_dbe_count", dbe_count, 2'd0);
    m = 0;
    sent = 0;
    nv = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (sent < 5);
      in_op    = 1'b1;
      in_word  = 13'h0007;
      chk($sformatf("sat_c%0d_sbe_count", cyc), sbe_count, m);
      if (out_valid) begin
        nv++;
        if (m < 3) m++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("sat_delivered", nv, 5);
    chk("sat_sbe_count", sbe_count, 2'd3);

    // cnt_clr in the same cycle as an SBE handshake: clear wins.
    out_ready = 1'b0;
    send_one(1'b1, 13'h0007, lat);
    chk("clrwin_stalled_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    chk("clrwin_stall_count", sbe_count, 2'd3);
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clrwin_sbe_count", sbe_count, 2'd0);
    chk("clrwin_drained", out_valid, 1'b0);
    send_one(1'b1, 13'h0023, lat);
    @(posedge clk); #1;
    chk("clrwin_next_count", sbe_count, 2'd1);

    // Let the wide-instance checks complete before disturbing the shared reset.
    for (int c = 0; c < 5000 && !(g_w[0].done_w && g_w[1].done_w && g_w[2].done_w); c++)
      @(posedge clk);
    #1;
    chk("wide_done", {g_w[0].done_w, g_w[1].done_w, g_w[2].done_w}, 3'b111);

    // Reset with two words in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 1'b1;
    in_word   = 13'h0023;
    @(posedge clk); #1;
    in_op   = 1'b0;
    in_word = 13'h00A5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_full_valid", out_valid, 1'b1);
    chk("mid_full_in_ready", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_counts", {sbe_count, dbe_count}, 4'h0);
    chk("mid_rst_out_code", out_code, 13'h0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    nv = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) nv++;
    end
    chk("mid_rst_no_spurious", nv, 0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_counts_after", {sbe_count, dbe_count}, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hsiao_secded_codec.md
# hsiao_secded_codec

Parametrised, pipelined Hsiao SEC-DED codec that encodes or decodes one word per transaction on a valid/ready stream. It replaces the fixed 8-bit combinational encoder in the memory-protection path and supports 4–64 bit data. It corrects single-bit errors, detects double-bit errors, and keeps saturating error counters for scrubbing and telemetry.

## Interface

Parameters:

- `DATA_W`, 8, data width; legal range 4–64.
- `CNT_W`, 16, width of each error counter.
- `P` (localparam), check-bit count: the smallest r with the sum of C(r,w) over odd w≥3 being ≥ `DATA_W`. Values: 8→5, 16→6, 32→7, 64→8.
- `CODE_W` (localparam), `DATA_W+P`.

Ports:

- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: input word present.
- `in_ready`, out, 1: codec accepts the word this cycle.
- `in_op`, in, 1: 0 = encode, 1 = decode.
- `in_word`, in, `CODE_W`: decode uses the full codeword; encode uses only `[DATA_W-1:0]`, and upper bits are ignored.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: downstream accepts the result.
- `out_code`, out, `CODE_W`: encoded codeword, or corrected codeword on decode.
- `out_data`, out, `DATA_W`: the data field (corrected on decode).
- `out_sbe`, out, 1: single-bit error corrected.
- `out_dbe`, out, 1: uncorrectable error detected.
- `out_syndrome`, out, `P`: raw syndrome; 0 on encode.
- `cnt_clr`, in, 1: synchronous clear of both counters.
- `sbe_count`, out, `CNT_W`: corrected-error count, saturating.
- `dbe_count`, out, `CNT_W`: uncorrectable-error count, saturating.

## Operation

**Codeword layout**
- `code[CODE_W-1:P]` = data, with data bit 0 at `code[P]`.
- `code[P-1:0]` = check bits.

**H-matrix columns**
- Data bit i takes the i-th value in this list: all P-bit values of weight 3 in ascending numeric order, then weight 5 ascending, then weight 7, and so on.
- Check bit j takes the column 1<<j.
- Check bit j = XOR of all data bits whose column has bit j set.

**Encode** (`in_op`=0)
- `out_code` = {data, check}.
- `out_data` = data.
- `out_sbe`=0, `out_dbe`=0, `out_syndrome`=0.

**Decode** (`in_op`=1)
- Syndrome s = received check bits XOR check bits recomputed from the received data.
- s = 0: no error; the word passes unchanged.
- s has odd weight and equals a data or check column: flip that bit and set `out_sbe`=1.
- s is nonzero even weight, or odd weight matching no column: set `out_dbe`=1. The word passes uncorrected.
- `out_sbe` and `out_dbe` are never both 1.

**Counters**
- A counter increments by 1 on an output handshake (`out_valid && out_ready`) with the matching flag set.
- Counters saturate at 2^`CNT_W`−1.
- If `cnt_clr` and an increment occur in the same cycle, clear wins and the event is not counted.

**Reset values**
- All valids, flags, data, code, syndrome and counters are 0.
- `in_ready` is 1 from the first cycle after reset deassertion.

## Timing

**Pipeline**
- Stage S1 registers the op and word, and computes the syndrome or check bits.
- Stage S2 registers the correction result, the flags and the outputs.
- Latency is exactly 2 cycles from the input handshake to `out_valid`, given `out_ready`=1.
- Throughput is 1 word/cycle.

**Stall rules**
- S2 loads when `!out_valid || out_ready`.
- S1 advances when S2 loads or S1 is empty.
- `in_ready` = `!s1_valid || s2_load`. This is combinational from `out_ready`; there is no skid buffer.
- While `out_valid && !out_ready`, all outputs hold stable.
- `in_op` may change every transaction; results never mix across transactions.

**Reset mid-stream**
- In-flight words are discarded and no handshake completes.
- Counters return to 0.

## Structure

- Package `hsiao_pkg` holds:
  - function `hsiao_check_bits(data_w)`, which computes P;
  - function `hsiao_column(data_w, i)`, which returns the P-bit column for data bit i;
  - the op encoding constants `OP_ENC`=0 and `OP_DEC`=1.
- Sub-module `hsiao_check_gen` is a parametrised combinational parity tree (data → P check bits). It is instantiated once and shared by encode and decode.
- The codec top holds the pipeline registers, correction logic and counters.

## Test plan

All scenarios use `DATA_W`=8, so P=5 and the data columns are 0x07, 0x0B, 0x0D, 0x0E, 0x13, 0x15, 0x16, 0x19.

- **Encode**: data 0x01 → `out_code`=0x027 two cycles later. Data 0xFF → 0x1FE6. Data 0x00 → 0x000.
- **Single-bit correction**: decode 0x027 with bit 5 flipped (0x007) → syndrome 0x07, `out_data`=0x01, `out_code`=0x027, `out_sbe`=1, `sbe_count`=1. Flipping check bit 2 (0x023) → syndrome 0x04, `out_sbe`=1.
- **Double-bit detection**: decode 0x027 with bits 0 and 1 flipped (0x024) → syndrome 0x03, `out_dbe`=1, `out_data`=0x01, `dbe_count`=1.
- **Back-pressure**: stream 10 mixed encode/decode words with `out_ready` toggling randomly → every result is delivered exactly once, in order, and outputs hold stable while stalled.
- **Counters**: with `CNT_W`=2, 5 SBE words → `sbe_count` saturates at 3. Asserting `cnt_clr` in the same cycle as an SBE handshake → count 0.
- **Reset and scaling**: assert `rst_n`=0 with 2 words in flight → `out_valid`=0 and counters 0, with no spurious output after release. Repeat the encode/SBE/DBE checks for `DATA_W`=16, 32 and 64 against a reference model built from the same column rule.
